// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - condition codes and flag bit positions for cond_unit
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational ARM condition-field evaluation against {N,Z,C,V}
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    // Decode the condition field; the 1111 encoding never passes.
    always_comb begin
        pass = 1'b0;
        case (cond_e'(Cond))
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - conditional-execution unit with flag register; COND_STATS_EN adds exec/skip counters
module cond_unit
    import cond_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic [3:0] Cond,
    input  logic [1:0] FlagW,
    input  logic [3:0] ALUFlags,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    input  logic       flags_wr_en,
    input  logic [3:0] flags_wr_data,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags,
    output logic       carry_out
`ifdef COND_STATS_EN
    ,
    output logic [15:0] exec_count,
    output logic [15:0] skip_count
`endif
);

    logic pass;

    cond_check u_cond_check (
        .Cond  (Cond),
        .Flags (Flags),
        .pass  (pass)
    );

    // Condition is evaluated against the registered flags, so a flag-setting
    // instruction sees the values from before its own update.
    assign CondEx    = instr_valid & pass & ~reset;
    assign PCSrc     = PCS & CondEx;
    assign RegWrite  = RegW & CondEx & ~NoWrite;
    assign MemWrite  = MemW & CondEx;
    assign carry_out = Flags[FLAG_C];

    // Flag register: reset beats direct write, direct write beats ALU update.
    always_ff @(posedge clk) begin
        if (reset) begin
            Flags <= 4'b0000;
        end else if (flags_wr_en) begin
            Flags <= flags_wr_data;
        end else if (CondEx) begin
            if (FlagW[1]) begin
                Flags[FLAG_N] <= ALUFlags[FLAG_N];
                Flags[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (FlagW[0]) begin
                Flags[FLAG_C] <= ALUFlags[FLAG_C];
                Flags[FLAG_V] <= ALUFlags[FLAG_V];
            end
        end
    end

`ifdef COND_STATS_EN
    // Saturating counters of executed and skipped valid instructions.
    always_ff @(posedge clk) begin
        if (reset) begin
            exec_count <= 16'h0000;
            skip_count <= 16'h0000;
        end else if (instr_valid) begin
            if (pass) begin
                if (exec_count != 16'hFFFF) exec_count <= exec_count + 16'h0001;
            end else begin
                if (skip_count != 16'hFFFF) skip_count <= skip_count + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - table-driven scoreboard bench for cond_unit
module tb_cond_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [3:0] Cond;
    logic [1:0] FlagW;
    logic [3:0] ALUFlags;
    logic       PCS, RegW, MemW, NoWrite;
    logic       flags_wr_en;
    logic [3:0] flags_wr_data;
    logic       PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0] Flags;
    logic       carry_out;
`ifdef COND_STATS_EN
    logic [15:0] exec_count, skip_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cond_unit dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .Cond          (Cond),
        .FlagW         (FlagW),
        .ALUFlags      (ALUFlags),
        .PCS           (PCS),
        .RegW          (RegW),
        .MemW          (MemW),
        .NoWrite       (NoWrite),
        .flags_wr_en   (flags_wr_en),
        .flags_wr_data (flags_wr_data),
        .PCSrc         (PCSrc),
        .RegWrite      (RegWrite),
        .MemWrite      (MemWrite),
        .CondEx        (CondEx),
        .Flags         (Flags),
        .carry_out     (carry_out)
`ifdef COND_STATS_EN
        ,
        .exec_count    (exec_count),
        .skip_count    (skip_count)
`endif
    );

    typedef struct {
        string      name;
        logic       rst;
        logic       iv;
        logic [3:0] cond;
        logic [1:0] flagw;
        logic [3:0] alu;
        logic       pcs, regw, memw, nowr;
        logic       fwe;
        logic [3:0] fwd;
        logic       ex, pcsrc, regwr, memwr;
        logic [3:0] flags;
    } vec_t;

    typedef struct {
        string      name;
        logic       ex, pcsrc, regwr, memwr;
        logic [3:0] flags;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(string name, logic rst, logic iv, logic [3:0] cond,
                                logic [1:0] flagw, logic [3:0] alu, logic pcs, logic regw,
                                logic memw, logic nowr, logic fwe, logic [3:0] fwd,
                                logic ex, logic pcsrc, logic regwr, logic memwr,
                                logic [3:0] flags);
        vec_t v;
        v.name = name; v.rst = rst; v.iv = iv; v.cond = cond; v.flagw = flagw;
        v.alu = alu; v.pcs = pcs; v.regw = regw; v.memw = memw; v.nowr = nowr;
        v.fwe = fwe; v.fwd = fwd; v.ex = ex; v.pcsrc = pcsrc; v.regwr = regwr;
        v.memwr = memwr; v.flags = flags;
        return v;
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        reset         = v.rst;
        instr_valid   = v.iv;
        Cond          = v.cond;
        FlagW         = v.flagw;
        ALUFlags      = v.alu;
        PCS           = v.pcs;
        RegW          = v.regw;
        MemW          = v.memw;
        NoWrite       = v.nowr;
        flags_wr_en   = v.fwe;
        flags_wr_data = v.fwd;
    endtask

    task automatic apply(vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        drive(v);
        e.name = v.name; e.ex = v.ex; e.pcsrc = v.pcsrc; e.regwr = v.regwr;
        e.memwr = v.memwr; e.flags = v.flags;
        sb.push_back(e);
        #2;
        got = sb.pop_front();
        check({got.name, ".CondEx"},   {15'd0, CondEx},   {15'd0, got.ex});
        check({got.name, ".PCSrc"},    {15'd0, PCSrc},    {15'd0, got.pcsrc});
        check({got.name, ".RegWrite"}, {15'd0, RegWrite}, {15'd0, got.regwr});
        check({got.name, ".MemWrite"}, {15'd0, MemWrite}, {15'd0, got.memwr});
        @(posedge clk);
        #1;
        check({got.name, ".Flags"},     {12'd0, Flags},     {12'd0, got.flags});
        check({got.name, ".carry_out"}, {15'd0, carry_out}, {15'd0, got.flags[1]});
    endtask

    initial begin
        //           name         rst iv  cond     fw     alu      pcs regw memw nowr fwe fwd      ex pc rw mw flags
        vecs.push_back(mk("reset",    1, 1, 4'b1110, 2'b11, 4'b1111, 1, 1, 1, 0, 1, 4'b1111, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("eq_fail",  0, 1, 4'b0000, 2'b11, 4'b1111, 0, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("ne_pass",  0, 1, 4'b0001, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 4'b0000, 1, 0, 1, 0, 4'b0000));
        vecs.push_back(mk("cmp",      0, 1, 4'b1110, 2'b11, 4'b0100, 0, 1, 0, 1, 0, 4'b0000, 1, 0, 0, 0, 4'b0100));
        vecs.push_back(mk("eq_after", 0, 1, 4'b0000, 2'b00, 4'b0000, 0, 1, 1, 0, 0, 4'b0000, 1, 0, 1, 1, 4'b0100));
        vecs.push_back(mk("clr0",     0, 0, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("nz_only",  0, 1, 4'b1110, 2'b10, 4'b1111, 0, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 4'b1100));
        vecs.push_back(mk("clr1",     0, 0, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("gt_wrwin", 0, 1, 4'b1100, 2'b11, 4'b0110, 1, 0, 0, 0, 1, 4'b1001, 1, 1, 0, 0, 4'b1001));
        vecs.push_back(mk("gt_next",  0, 1, 4'b1100, 2'b00, 4'b0000, 1, 0, 0, 0, 0, 4'b0000, 1, 1, 0, 0, 4'b1001));
        vecs.push_back(mk("lt_fail",  0, 1, 4'b1011, 2'b11, 4'b1111, 0, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b1001));
        vecs.push_back(mk("nv",       0, 1, 4'b1111, 2'b11, 4'b0000, 1, 1, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b1001));
        vecs.push_back(mk("iv0",      0, 0, 4'b1110, 2'b11, 4'b0000, 1, 1, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b1001));
        vecs.push_back(mk("hi_fail",  0, 1, 4'b1000, 2'b00, 4'b0000, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b1001));
        vecs.push_back(mk("ls_cv",    0, 1, 4'b1001, 2'b01, 4'b0010, 0, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 4'b1010));
        vecs.push_back(mk("hi_pass",  0, 1, 4'b1000, 2'b00, 4'b0000, 0, 0, 1, 0, 0, 4'b0000, 1, 0, 0, 1, 4'b1010));
        vecs.push_back(mk("cs_pass",  0, 1, 4'b0010, 2'b01, 4'b0011, 0, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 4'b1011));
        vecs.push_back(mk("vs_self",  0, 1, 4'b0110, 2'b01, 4'b0000, 0, 1, 0, 0, 0, 4'b0000, 1, 0, 1, 0, 4'b1000));
        vecs.push_back(mk("vs_fail",  0, 1, 4'b0110, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b1000));
        vecs.push_back(mk("vc_pass",  0, 1, 4'b0111, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 4'b0000, 1, 0, 1, 0, 4'b1000));
        vecs.push_back(mk("mi_pass",  0, 1, 4'b0100, 2'b00, 4'b0000, 1, 0, 0, 0, 0, 4'b0000, 1, 1, 0, 0, 4'b1000));
        vecs.push_back(mk("pl_fail",  0, 1, 4'b0101, 2'b00, 4'b0000, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b1000));
        vecs.push_back(mk("ge_fail",  0, 1, 4'b1010, 2'b00, 4'b0000, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b1000));
        vecs.push_back(mk("le_pass",  0, 1, 4'b1101, 2'b00, 4'b0000, 1, 0, 0, 0, 0, 4'b0000, 1, 1, 0, 0, 4'b1000));
        vecs.push_back(mk("cc_pass",  0, 1, 4'b0011, 2'b11, 4'b0110, 0, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 4'b0110));
        vecs.push_back(mk("mid_rst",  1, 1, 4'b1110, 2'b11, 4'b1111, 1, 1, 1, 0, 1, 4'b1111, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("post_eq",  0, 1, 4'b0000, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("post_ne",  0, 1, 4'b0001, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 4'b0000, 1, 0, 1, 0, 4'b0000));

        drive(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        check("init.Flags", {12'd0, Flags}, 16'h0000);
        check("init.CondEx", {15'd0, CondEx}, 16'h0000);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

`ifdef COND_STATS_EN
        @(negedge clk);
        reset = 1'b1; flags_wr_en = 1'b0; instr_valid = 1'b1; Cond = 4'b1110; FlagW = 2'b00;
        @(posedge clk); #1;
        check("stats.rst_exec", exec_count, 16'h0000);
        check("stats.rst_skip", skip_count, 16'h0000);
        @(negedge clk);
        reset = 1'b0; Cond = 4'b1111;
        @(posedge clk); #1;
        check("stats.skip1", skip_count, 16'h0001);
        check("stats.exec0", exec_count, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("stats.rst2_skip", skip_count, 16'h0000);
        @(negedge clk);
        reset = 1'b0; Cond = 4'b1110;
        repeat (65540) @(posedge clk);
        #1;
        check("stats.exec_sat", exec_count, 16'hFFFF);
        check("stats.skip_zero", skip_count, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("stats.rst3_exec", exec_count, 16'h0000);
        check("stats.rst3_skip", skip_count, 16'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
